// File: rtl/cp0.sv
// Coprocessor-0 interrupt/exception controller: SR, Cause, EPC and PrID registers,
// hardware interrupt sampling and handler-entry decision for the pipeline.
module cp0 #(
  parameter logic [31:0] PRID = 32'h0000_7001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] pc,
  input  logic        in_delay_slot,
  input  logic        eret,
  output logic        int_req,
  output logic [31:0] epc
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code_reg;
  logic [31:0] epc_reg;

  logic        int_pending;
  logic [31:0] victim_pc;
  logic [31:0] sr_value;
  logic [31:0] cause_value;

  // Pending interrupts look at the raw lines so the request is zero-latency.
  assign int_pending = (|(hw_int & im)) & ie & ~exl;
  assign int_req     = (int_pending | exc_valid) & ~exl;
  assign victim_pc   = in_delay_slot ? (pc - 32'd4) : pc;
  assign epc         = epc_reg;

  assign sr_value    = {16'h0000, im, 8'h00, exl, ie};
  assign cause_value = {bd, 15'h0000, ip, 3'b000, exc_code_reg, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      im           <= 6'h00;
      exl          <= 1'b0;
      ie           <= 1'b0;
      bd           <= 1'b0;
      ip           <= 6'h00;
      exc_code_reg <= 5'd0;
      epc_reg      <= 32'h0000_0000;
    end else begin
      ip <= hw_int;
      if (int_req) begin
        exl          <= 1'b1;
        bd           <= in_delay_slot;
        epc_reg      <= {victim_pc[31:2], 2'b00};
        exc_code_reg <= int_pending ? 5'd0 : exc_code;
      end else begin
        if (write_enable) begin
          if (addr == ADDR_SR) begin
            im  <= write_data[15:10];
            exl <= write_data[1];
            ie  <= write_data[0];
          end else if (addr == ADDR_EPC) begin
            epc_reg <= {write_data[31:2], 2'b00};
          end
        end
        // Placed after the write so eret wins over an SR write on the same edge.
        if (eret) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    read_result = 32'h0000_0000;
    case (addr)
      ADDR_SR:    read_result = sr_value;
      ADDR_CAUSE: read_result = cause_value;
      ADDR_EPC:   read_result = epc_reg;
      ADDR_PRID:  read_result = PRID;
      default:    read_result = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0: reset, interrupt/exception entry, masking,
// priority, nested blocking, eret re-enable and mtc0 collisions.
module tb_cp0;

  logic        clk;
  logic        rst;
  logic [4:0]  addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] pc;
  logic        in_delay_slot;
  logic        eret;
  logic        int_req;
  logic [31:0] epc;

  int compared;
  int mismatched;

  cp0 #(.PRID(32'h0000_7001)) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .write_enable(write_enable),
    .write_data(write_data),
    .read_result(read_result),
    .hw_int(hw_int),
    .exc_valid(exc_valid),
    .exc_code(exc_code),
    .pc(pc),
    .in_delay_slot(in_delay_slot),
    .eret(eret),
    .int_req(int_req),
    .epc(epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Consume one rising edge; inputs are changed 1 time unit after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input logic [4:0] a, input string tag, input logic [31:0] expected);
    addr = a;
    #1;
    checkOutput(tag, read_result, expected);
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    addr = a;
    write_data = d;
    write_enable = 1'b1;
    applyStimulus();
    write_enable = 1'b0;
  endtask

  task automatic doEret();
    eret = 1'b1;
    applyStimulus();
    eret = 1'b0;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    addr = 5'd0;
    write_enable = 1'b0;
    write_data = 32'h0;
    hw_int = 6'h00;
    exc_valid = 1'b0;
    exc_code = 5'd0;
    pc = 32'h0;
    in_delay_slot = 1'b0;
    eret = 1'b0;

    // Reset state
    applyStimulus();
    rst = 1'b0;
    readReg(5'd12, "reset_sr", 32'h0);
    readReg(5'd13, "reset_cause", 32'h0);
    readReg(5'd14, "reset_epc", 32'h0);
    readReg(5'd15, "reset_prid", 32'h0000_7001);
    readReg(5'd5, "unmapped_read", 32'h0);
    checkOutput("reset_epc_port", epc, 32'h0);
    hw_int = 6'h3F;
    #1;
    checkOutput("reset_int_req", {31'b0, int_req}, 32'h0);
    hw_int = 6'h00;

    // Timer interrupt
    writeReg(5'd12, 32'h0000_0401);
    hw_int = 6'h01;
    pc = 32'h0000_3010;
    in_delay_slot = 1'b0;
    #1;
    checkOutput("timer_int_req", {31'b0, int_req}, 32'h1);
    applyStimulus();
    checkOutput("timer_int_req_drop", {31'b0, int_req}, 32'h0);
    readReg(5'd12, "timer_sr", 32'h0000_0403);
    readReg(5'd14, "timer_epc", 32'h0000_3010);
    readReg(5'd13, "timer_cause", 32'h0000_0400);
    checkOutput("timer_epc_port", epc, 32'h0000_3010);
    hw_int = 6'h00;
    doEret();
    readReg(5'd12, "timer_sr_after_eret", 32'h0000_0401);

    // Delay-slot exception
    exc_valid = 1'b1;
    exc_code = 5'd4;
    pc = 32'h0000_3008;
    in_delay_slot = 1'b1;
    #1;
    checkOutput("ds_int_req", {31'b0, int_req}, 32'h1);
    applyStimulus();
    exc_valid = 1'b0;
    in_delay_slot = 1'b0;
    readReg(5'd14, "ds_epc", 32'h0000_3004);
    readReg(5'd13, "ds_cause", 32'h8000_0010);
    doEret();

    // Masked interrupts, exception gets its own code
    writeReg(5'd12, 32'h0000_0001);
    hw_int = 6'h3F;
    #1;
    checkOutput("masked_int_req", {31'b0, int_req}, 32'h0);
    exc_valid = 1'b1;
    exc_code = 5'd10;
    pc = 32'h0000_3020;
    #1;
    checkOutput("masked_exc_int_req", {31'b0, int_req}, 32'h1);
    applyStimulus();
    exc_valid = 1'b0;
    readReg(5'd13, "masked_cause", 32'h0000_FC28);
    readReg(5'd14, "masked_epc", 32'h0000_3020);
    doEret();
    readReg(5'd12, "masked_sr", 32'h0000_0001);

    // Interrupt beats a simultaneous exception
    writeReg(5'd12, 32'h0000_FC01);
    exc_valid = 1'b1;
    exc_code = 5'd10;
    pc = 32'h0000_3030;
    #1;
    checkOutput("prio_int_req", {31'b0, int_req}, 32'h1);
    applyStimulus();
    exc_valid = 1'b0;
    readReg(5'd13, "prio_cause", 32'h0000_FC00);
    readReg(5'd14, "prio_epc", 32'h0000_3030);

    // Nested requests are blocked while EXL is set
    exc_valid = 1'b1;
    pc = 32'h0000_4000;
    #1;
    checkOutput("nested_int_req", {31'b0, int_req}, 32'h0);
    applyStimulus();
    exc_valid = 1'b0;
    readReg(5'd14, "nested_epc", 32'h0000_3030);
    doEret();
    checkOutput("eret_reassert", {31'b0, int_req}, 32'h1);
    readReg(5'd12, "eret_sr", 32'h0000_FC01);

    // mtc0 EPC loses to an interrupt entry on the same edge
    pc = 32'h0000_5000;
    writeReg(5'd14, 32'h1234_5677);
    readReg(5'd14, "collide_epc", 32'h0000_5000);
    hw_int = 6'h00;
    doEret();
    writeReg(5'd14, 32'h1234_5677);
    readReg(5'd14, "write_epc", 32'h1234_5674);
    writeReg(5'd13, 32'hFFFF_FFFF);
    readReg(5'd13, "cause_readonly", 32'h0000_0000);
    writeReg(5'd15, 32'hFFFF_FFFF);
    readReg(5'd15, "prid_readonly", 32'h0000_7001);

    // SR write together with eret leaves EXL clear
    eret = 1'b1;
    writeReg(5'd12, 32'hFFFF_FC03);
    eret = 1'b0;
    readReg(5'd12, "sr_write_eret", 32'h0000_FC01);

    // Delay-slot EPC wraps below zero
    exc_valid = 1'b1;
    exc_code = 5'd12;
    pc = 32'h0000_0000;
    in_delay_slot = 1'b1;
    applyStimulus();
    exc_valid = 1'b0;
    in_delay_slot = 1'b0;
    readReg(5'd14, "wrap_epc", 32'hFFFF_FFFC);
    readReg(5'd13, "wrap_cause", 32'h8000_0030);

    // Reset during EXL=1; IP is not sampled on the reset edge
    rst = 1'b1;
    hw_int = 6'h3F;
    applyStimulus();
    rst = 1'b0;
    readReg(5'd12, "midreset_sr", 32'h0);
    readReg(5'd13, "midreset_cause", 32'h0);
    readReg(5'd14, "midreset_epc", 32'h0);
    checkOutput("midreset_int_req", {31'b0, int_req}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
